// File: rtl/uart_rx_byte.sv
// UART receive byte assembler: two-flop rx synchronizer, start-bit qualification,
// mid-bit sampling of 8 LSB-first data bits and stop-bit check with one-cycle strobes.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    localparam logic [15:0] HalfLast = 16'(HALF_BIT - 1);
    localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);

    state_e      state_q, state_d;
    logic        rx_m, rx_s;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = 16'd0;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = 16'd0;
                    // A start bit that is high again at its midpoint was only a glitch.
                    if (!rx_s) begin
                        state_d   = StData;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = 16'd0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    // Leave at mid stop bit so a back-to-back start edge is not missed.
                    cnt_d   = 16'd0;
                    state_d = StIdle;
                    if (rx_s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomised scoreboard bench for uart_rx_byte: stimulus pushes expected strobes,
// a negedge monitor pops and compares kind, data and exact cycle of each strobe.
module tb_uart_rx_byte;

    localparam int unsigned CPB = 16;
    localparam int unsigned HB  = 8;
    // Drive cycle -> strobe cycle: next edge captures, 2 sync, half bit, 9 full bits.
    localparam int unsigned LAT = 1 + 2 + HB + 9 * CPB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_byte #(
        .CLKS_PER_BIT(CPB),
        .HALF_BIT    (HB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    typedef struct {
        logic        is_err;
        logic [7:0]  data_after;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    logic [7:0]  last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: valid=%b frame_err=%b data=%h, expected none",
                         valid, frame_err, data);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_valid", 32'(valid), 32'(!mon_e.is_err));
                check("pulse_frame_err", 32'(frame_err), 32'(mon_e.is_err));
                check("pulse_data", 32'(data), 32'(mon_e.data_after));
                check("pulse_cycle", cyc, mon_e.cyc);
                check("pulse_busy", 32'(busy), 0);
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int unsigned n);
        rx = 1'b1;
        tick(n);
    endtask

    // Reference: a frame with a high stop bit delivers its byte; otherwise a
    // framing error is reported and the previously delivered byte is kept.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        exp_t       e;
        logic [9:0] bits;
        bits         = {stop, b, 1'b0};
        e.is_err     = !stop;
        e.data_after = stop ? b : last_good;
        e.cyc        = cyc + LAT;
        if (stop) last_good = b;
        exp_q.push_back(e);
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            tick(CPB);
        end
    endtask

    task automatic glitch(input int unsigned len);
        rx = 1'b0;
        tick(len);
        rx = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        exp_q.delete();
        last_good = 8'h00;
        tick(1);
        check("rst_data", 32'(data), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_busy", 32'(busy), 0);
        tick(4);
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned bad;
        int unsigned kind;
        logic        gap_needed;

        @(posedge clk);
        #1;
        do_reset();

        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (valid || frame_err || busy || data != 8'h00) bad++;
        end
        check("reset_quiet", bad, 0);

        send_frame(8'h55, 1'b1);
        idle(20);
        check("single_data", 32'(data), 32'h55);

        send_frame(8'hA5, 1'b0);
        idle(20);
        check("ferr_data_hold", 32'(data), 32'h55);

        glitch(4);
        check("glitch_busy_high", 32'(busy), 1);
        idle(10);
        check("glitch_busy_low", 32'(busy), 0);
        send_frame(8'h3C, 1'b1);
        idle(20);
        check("after_glitch_data", 32'(data), 32'h3C);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        check("b2b_data", 32'(data), 32'hFF);

        // Frame 0x81 aborted by reset in the middle of data bit 3.
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(CPB);
        rx = 1'b0;
        tick(2 * CPB + CPB / 2);
        check("midframe_busy", 32'(busy), 1);
        do_reset();
        check("midframe_rst_data", 32'(data), 0);
        idle(20);
        send_frame(8'h3C, 1'b1);
        idle(20);
        check("post_reset_data", 32'(data), 32'h3C);

        gap_needed = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (gap_needed) idle($urandom_range(30, 12));
            else            idle($urandom_range(20, 0));
            kind = $urandom_range(9, 0);
            if (kind < 2) begin
                glitch($urandom_range(5, 1));
                gap_needed = 1'b1;
            end else begin
                logic stop;
                stop = ($urandom_range(4, 0) != 0);
                send_frame(8'($urandom), stop);
                gap_needed = !stop;
            end
        end
        idle(20);

        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
        check("queue_drained", exp_q.size(), 0);
        check("final_data", 32'(data), 32'(last_good));
        check("final_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

UART receive byte assembler for the 16_2 UART design. It takes the raw asynchronous `rx` line and synchronizes it, then detects and qualifies the start bit. It samples 8 data bits LSB-first at mid-bit and checks the stop bit, emitting each byte with a one-cycle `valid` strobe. It is the stage directly downstream of receive bit timing: it owns its own mid-bit sampling counter and produces bytes for the application or FIFO stage.

## Interface
- `CLKS_PER_BIT`, default 5208: `clk` cycles per UART bit (50 MHz / 9600 baud). Legal range 4..65535.
- `HALF_BIT`, default `CLKS_PER_BIT/2`: cycles from detected start edge to the start-bit sample point.
- `clk`, input, 1: system clock, rising-edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `rx`, input, 1: raw serial line, idle high, asynchronous to `clk`.
- `data`, output, 8: last correctly framed byte; holds until the next good frame.
- `valid`, output, 1: one-cycle pulse when `data` is updated.
- `frame_err`, output, 1: one-cycle pulse when the stop bit samples low.
- `busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer:** `rx` passes through 2 flops, `rx_m` then `rx_s`; both reset to 1. All decisions use `rx_s` only.
- **Counter:** `cnt` is 16 bits and resets to 0. It clears on every state transition and on every sample point, and otherwise increments each cycle.
- **Bit index:** `bit_idx` is 3 bits. The shift register `shreg` is 8 bits and shifts right, so a new bit enters at bit 7, giving LSB-first order.
- **States:**
  - **IDLE:**
    - `rx_s==0` -> go to START, `cnt<=0`.
    - Otherwise stay in IDLE.
  - **START:**
    - When `cnt==HALF_BIT-1`, sample `rx_s`.
    - `rx_s==0` -> go to DATA, `cnt<=0`, `bit_idx<=0`.
    - `rx_s==1` -> the start bit was a glitch; go to IDLE with no output pulse.
  - **DATA:**
    - When `cnt==CLKS_PER_BIT-1`, do `shreg<={rx_s,shreg[7:1]}` and `cnt<=0`.
    - If `bit_idx==7`, go to STOP; otherwise `bit_idx<=bit_idx+1`.
  - **STOP:**
    - When `cnt==CLKS_PER_BIT-1`, sample `rx_s`.
    - `rx_s==1` -> `data<=shreg`, `valid<=1`.
    - `rx_s==0` -> `frame_err<=1`; `data` is unchanged.
    - Go to IDLE in either case. This is the middle of the stop bit, so a following start edge is caught with no gap required.
- **Output pulses:** `valid` and `frame_err` are registered and deasserted on every cycle they are not set.
- **No backpressure:** a byte not consumed in its `valid` cycle is overwritten by the next frame.
- **Reset:** assertion at any time, including mid-frame, forces the following and aborts the partial frame:
  - state = IDLE
  - `cnt=0`, `bit_idx=0`, `shreg=0`
  - `data=8'h00`, `valid=0`, `frame_err=0`, `busy=0`
  - `rx_m=rx_s=1`
- **Line state:** `rx` held low permanently causes repeated START->DATA->STOP->`frame_err` cycles. The block never hangs.

## Timing
- **Reset values:** `data=0`, `valid=0`, `frame_err=0`, `busy=0`.
- **Synchronizer latency:** 2 cycles. A low captured by `rx_m` at edge t0 is seen by the FSM at edge t0+2 (edge E). `busy` is high from E+1.
- **Start sample:** at edge E+HALF_BIT.
- **Data sample n (n=0..7):** at edge E+HALF_BIT+(n+1)·CLKS_PER_BIT.
- **Stop sample:** at edge E+HALF_BIT+9·CLKS_PER_BIT. `valid` or `frame_err` is high for exactly the one cycle following it, and `busy` drops in that same cycle.
- **Glitch rejection:** a low shorter than about HALF_BIT cycles is rejected. `busy` falls after edge E+HALF_BIT.
- **Tolerance:** sampling error is ±1 cycle plus synchronizer skew. Tolerated baud mismatch is up to about ±4 % at the default parameter.

## Test plan
All scenarios use `CLKS_PER_BIT=16` and `HALF_BIT=8`, with `rx` driven at exactly 16 clk per bit.
- **Reset:** hold `rst_n` low, then release it with `rx` high -> all outputs 0, `busy=0`, no pulses for 200 cycles.
- **Single frame:** frame 0x55 (start, 1,0,1,0,1,0,1,0, stop=1) with the start edge at t0 -> `valid` high one cycle after edge t0+154, `data=0x55`, `frame_err=0`.
- **Framing error:** receive 0x55 first, then frame 0xA5 with stop=0 -> one `frame_err` pulse, no `valid`, `data` stays 0x55.
- **Start glitch:** `rx` low for 4 cycles, then high -> `busy` high about 8 cycles, then low; no `valid` or `frame_err`; a following frame 0x3C is received correctly.
- **Back-to-back frames:** 0x00 then 0xFF, with the second start bit immediately after the first stop bit -> two `valid` pulses 160 cycles apart, `data` 0x00 then 0xFF.
- **Reset mid-frame:** assert `rst_n` low during data bit 3 of frame 0x81, then release and send 0x3C -> outputs reset to 0, no output from 0x81, then `valid` with `data=0x3C`.
